// File: rtl/inter_e2.sv
`default_nettype none
// ============================================================================
// Module   : inter_e2
// Purpose  : Row/column block interleaver for the turbo encode path.
//            A frame of ROWS*COLS four-lane groups is written in row-major
//            order. It is then read back in column-major order as four
//            packed {d, magnitude} soft words.
// Options  : INTER_E2_PINGPONG_EN - two memory banks. The writer fills
//            one bank while the other bank drains.
// Revision : 1.0 - initial release
// ============================================================================
module inter_e2 #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   d,
  input  logic [W-1:0] how_1,
  input  logic [W-1:0] how_2,
  input  logic [W-1:0] how_3,
  input  logic [W-1:0] how_4,
  output logic [W:0]   soft_out1,
  output logic [W:0]   soft_out2,
  output logic [W:0]   soft_out3,
  output logic [W:0]   soft_out4,
  output logic         out_valid,
  output logic         frame_done
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int EW = 4 * (W + 1);
`ifdef INTER_E2_PINGPONG_EN
  localparam int DEPTH = 2 * N;
`else
  localparam int DEPTH = N;
`endif
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_done_q, frame_done_d;
  logic [EW-1:0]   soft_q, soft_d;

  logic [EW-1:0]   mem [DEPTH];
  logic            accept;
  logic            rd_en;
  logic            rd_last;
  logic            mem_we;
  logic [AW-1:0]   rd_addr;
  logic [MW-1:0]   wr_idx;
  logic [MW-1:0]   rd_idx;
  logic [EW-1:0]   wr_entry;

`ifdef INTER_E2_PINGPONG_EN
  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;

  // A bank is drained for as long as it is marked full.
  // The writer stalls only when its own bank still holds an undrained frame.
  assign in_ready = ~full_q[wb_q];
  assign rd_en    = full_q[rb_q];
  assign wr_idx   = MW'(wb_q ? N : 0) + MW'(wr_addr_q);
  assign rd_idx   = MW'(rb_q ? N : 0) + MW'(rd_addr);
`else
  assign in_ready = (state_q != ST_DRAIN);
  assign rd_en    = (state_q == ST_DRAIN);
  assign wr_idx   = MW'(wr_addr_q);
  assign rd_idx   = MW'(rd_addr);
`endif

  assign accept   = in_valid & in_ready;
  assign rd_last  = (rd_cnt_q == AW'(N - 1));
  // Column-major address is built from row/col counters, so no divider is needed.
  assign rd_addr  = AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign wr_entry = {d[3], how_4, d[2], how_3, d[1], how_2, d[0], how_1};

  // Next state for the write-side FSM and the read counters.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_cnt_d  = rd_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    mem_we    = 1'b0;
`ifdef INTER_E2_PINGPONG_EN
    full_d    = full_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
`endif

    if (rd_en) begin
      if (rd_last) begin
        rd_cnt_d = '0;
        row_d    = '0;
        col_d    = '0;
`ifdef INTER_E2_PINGPONG_EN
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
`else
        state_d      = ST_IDLE;
`endif
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
        if (row_q == RW'(ROWS - 1)) begin
          row_d = '0;
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end
    end

    if (accept) begin
      mem_we = 1'b1;
      if (wr_addr_q == AW'(N - 1)) begin
        wr_addr_d = '0;
`ifdef INTER_E2_PINGPONG_EN
        // The reader never clears the writer's bank in the same cycle:
        // the writer is only active while its bank is not full.
        state_d      = ST_IDLE;
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
`else
        state_d      = ST_DRAIN;
`endif
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
        state_d   = ST_FILL;
      end
    end
  end

  // Next value of the read-data and output registers.
  // soft_* keeps its last value between frames.
  always_comb begin
    out_valid_d  = rd_en;
    frame_done_d = rd_en & rd_last;
    soft_d       = soft_q;
    if (rd_en) begin
      soft_d = mem[rd_idx];
    end
  end

  // Frame storage has no reset, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  // State and output registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      rd_cnt_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      soft_q       <= '0;
`ifdef INTER_E2_PINGPONG_EN
      full_q       <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      soft_q       <= soft_d;
`ifdef INTER_E2_PINGPONG_EN
      full_q       <= full_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
`endif
    end
  end

  assign soft_out1  = soft_q[W:0];
  assign soft_out2  = soft_q[2*W+1:W+1];
  assign soft_out3  = soft_q[3*W+2:2*W+2];
  assign soft_out4  = soft_q[4*W+3:3*W+3];
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_inter_e2.sv
`default_nettype none
// ============================================================================
// Module   : tb_inter_e2
// Purpose  : Directed self-checking bench for inter_e2 (ROWS=COLS=4, W=30).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inter_e2;

  localparam int W = 30;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   d;
  logic [W-1:0] how_1, how_2, how_3, how_4;
  logic [W:0]   soft_out1, soft_out2, soft_out3, soft_out4;
  logic         out_valid;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  inter_e2 #(.ROWS(4), .COLS(4), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d          (d),
    .how_1      (how_1),
    .how_2      (how_2),
    .how_3      (how_3),
    .how_4      (how_4),
    .soft_out1  (soft_out1),
    .soft_out2  (soft_out2),
    .soft_out3  (soft_out3),
    .soft_out4  (soft_out4),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector k: inputs of the k-th written group, expected words of the k-th output.
  typedef struct {
    logic [3:0]   d;
    logic [W-1:0] h1, h2, h3, h4;
    logic [W:0]   e1, e2, e3, e4;
  } vec_t;
  vec_t vecs[16];

  typedef struct {
    logic [W:0] s1, s2, s3, s4;
    logic       fd;
    logic       rdy;
    int         cyc;
  } obs_t;
  obs_t obs_q[$];

  // Record every valid output word with its cycle stamp.
  always @(negedge clk) begin
    obs_t o;
    if (out_valid) begin
      o.s1 = soft_out1; o.s2 = soft_out2; o.s3 = soft_out3; o.s4 = soft_out4;
      o.fd = frame_done; o.rdy = in_ready; o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Writes 16 groups starting at the current negedge; returns cycle stamp of the last write edge.
  task automatic write_frame(input int gap, input bit pack, output int t);
    t = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      if (pack) begin
        d = 4'b1010; how_1 = '0; how_2 = '0; how_3 = '0; how_4 = '0;
      end else begin
        d = vecs[k].d; how_1 = vecs[k].h1; how_2 = vecs[k].h2;
        how_3 = vecs[k].h3; how_4 = vecs[k].h4;
      end
      @(posedge clk);
      #1 t = cyc;
      @(negedge clk);
      if (gap > 0 && k < 15) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  task automatic wait_outs();
    for (int i = 0; i < 40 && obs_q.size() < 16; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Pops one frame of outputs and checks data, order, timing and frame_done.
  task automatic check_frame(input int t, input bit pack, input string name);
    obs_t o;
    logic [W:0] e1, e2, e3, e4;
    int first_cyc = 0;
    int fd_bad = 0;
    int gap_bad = 0;
    checks++;
    if (obs_q.size() < 16) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs expected 16", name, obs_q.size());
      obs_q.delete();
      return;
    end
    for (int j = 0; j < 16; j++) begin
      o = obs_q.pop_front();
      if (pack) begin
        e1 = '0; e2 = 31'h40000000; e3 = '0; e4 = 31'h40000000;
      end else begin
        e1 = vecs[j].e1; e2 = vecs[j].e2; e3 = vecs[j].e3; e4 = vecs[j].e4;
      end
      checks++;
      if (o.s1 !== e1 || o.s2 !== e2 || o.s3 !== e3 || o.s4 !== e4) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h %h %h %h expected %h %h %h %h",
                 name, j, o.s1, o.s2, o.s3, o.s4, e1, e2, e3, e4);
      end
      if (j == 0) begin
        first_cyc = o.cyc;
        chk({name, "_first_cycle"}, 32'(o.cyc), 32'(t + 1));
        chk({name, "_ready_low"}, {31'd0, o.rdy}, 32'd0);
      end
      if (o.cyc != first_cyc + j) gap_bad++;
      if (j < 15 && o.fd) fd_bad++;
      if (j == 15) begin
        chk({name, "_frame_done"}, {31'd0, o.fd}, 32'd1);
        chk({name, "_ready_back"}, {31'd0, o.rdy}, 32'd1);
      end
    end
    chk({name, "_contiguous"}, 32'(gap_bad), 32'd0);
    chk({name, "_early_done"}, 32'(fd_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[16];
    logic [3:0] kb;
    int t, t2, wait_n;

    ord = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    for (int i = 0; i < 16; i++) begin
      vecs[i].d  = 4'(i);
      vecs[i].h1 = 30'(i * 4 + 1);
      vecs[i].h2 = 30'(i * 4 + 2);
      vecs[i].h3 = 30'(i * 4 + 3);
      vecs[i].h4 = 30'(i * 4 + 4);
      kb = 4'(ord[i]);
      vecs[i].e1 = {kb[0], 30'(ord[i] * 4 + 1)};
      vecs[i].e2 = {kb[1], 30'(ord[i] * 4 + 2)};
      vecs[i].e3 = {kb[2], 30'(ord[i] * 4 + 3)};
      vecs[i].e4 = {kb[3], 30'(ord[i] * 4 + 4)};
    end

    rst = 1'b0; in_valid = 1'b0; d = '0;
    how_1 = '0; how_2 = '0; how_3 = '0; how_4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);
    chk("rst_soft1", {1'b0, soft_out1}, 32'd0);
    chk("rst_soft4", {1'b0, soft_out4}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back frame.
    write_frame(0, 1'b0, t);
    chk("b2b_ready_drop", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_outs();
    check_frame(t, 1'b0, "b2b");

    // in_valid every third cycle.
    write_frame(2, 1'b0, t);
    chk("gap_ready_drop", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_outs();
    check_frame(t, 1'b0, "gap");

    // in_valid held high with junk during DRAIN must be ignored.
    write_frame(0, 1'b0, t);
    d = '0; how_1 = 30'h3FFFFFFF; how_2 = '0; how_3 = '0; how_4 = '0;
    wait_n = 0;
    while (!in_ready && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk("hold_ready_return_cycle", 32'(cyc), 32'(t + 16));
    write_frame(0, 1'b0, t2);
    in_valid = 1'b0;
    check_frame(t, 1'b0, "hold_f1");
    wait_outs();
    check_frame(t2, 1'b0, "hold_f2");

    // Reset in the 8th DRAIN cycle aborts the frame.
    write_frame(0, 1'b0, t);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
    chk("abort_in_ready",   {31'd0, in_ready}, 32'd1);
    chk("abort_soft1", {1'b0, soft_out1}, 32'd0);
    chk("abort_soft2", {1'b0, soft_out2}, 32'd0);
    chk("abort_soft3", {1'b0, soft_out3}, 32'd0);
    chk("abort_soft4", {1'b0, soft_out4}, 32'd0);
    rst = 1'b1;
    obs_q.delete();
    repeat (25) @(negedge clk);
    chk("abort_no_output", 32'(obs_q.size()), 32'd0);
    write_frame(0, 1'b0, t);
    in_valid = 1'b0;
    wait_outs();
    check_frame(t, 1'b0, "after_rst");

    // Lane packing: only d bits 1 and 3 set, all magnitudes zero.
    write_frame(0, 1'b1, t);
    in_valid = 1'b0;
    wait_outs();
    check_frame(t, 1'b1, "pack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
